// File: rtl/vote_pkg.sv
// Shared definitions for the voting-window controller and its neighbours.
//   state_t   : controller state encoding (IDLE / VOTING / HOLD)
//   N_VOTERS  : number of judges feeding the 3-of-5 majority voter
//   ALL_VOTED : ballot value at which the window closes early
package vote_pkg;

  localparam int N_VOTERS = 5;

  localparam logic [N_VOTERS-1:0] ALL_VOTED = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VOTING = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/vote_window_ctrl_if.sv
// Control/ballot bundle between the session driver and vote_window_ctrl.
//   start, clear : single-cycle session start / abort pulses
//   btn          : synchronised judge buttons (bit0 = judge A .. bit4 = judge E)
//   votes        : latched ballot towards the majority voter
//   voting, done : window open / ballot frozen and valid
//   vote_cnt     : number of yes votes (0..5)
//   remaining    : cycles left in the window, 0 outside voting
// slave = controller side, master = driver/consumer side.
interface vote_window_ctrl_if
  import vote_pkg::*;
#(
  parameter int CNT_W = 10
);

  logic                start;
  logic                clear;
  logic [N_VOTERS-1:0] btn;
  logic [N_VOTERS-1:0] votes;
  logic                voting;
  logic                done;
  logic [2:0]          vote_cnt;
  logic [CNT_W-1:0]    remaining;

  modport slave (
    input  start, clear, btn,
    output votes, voting, done, vote_cnt, remaining
  );

  modport master (
    output start, clear, btn,
    input  votes, voting, done, vote_cnt, remaining
  );

endinterface

// File: rtl/vote_window_ctrl_popcount5.sv
// Five-bit ones counter used to report the number of yes votes.
//   bits : 5-bit ballot
//   cnt  : number of set bits, 0..5
module popcount5 (
  input  logic [4:0] bits,
  output logic [2:0] cnt
);

  // Sum of the five ballot bits, each zero-extended to the result width.
  always_comb begin
    cnt = {2'b00, bits[0]} + {2'b00, bits[1]} + {2'b00, bits[2]}
        + {2'b00, bits[3]} + {2'b00, bits[4]};
  end

endmodule

// File: rtl/vote_window_ctrl.sv
// Timed voting-session controller ahead of the 3-of-5 majority voter.
// Opens a window of WINDOW_CYCLES cycles on start, ORs judge buttons into a
// sticky ballot, then freezes the ballot (done) on timeout or when every judge
// has voted. clear aborts from any state and beats a simultaneous start.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : vote_window_ctrl_if slave modport (start/clear/btn in,
//              votes/voting/done/vote_cnt/remaining out)
module vote_window_ctrl
  import vote_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 10
) (
  input  logic               clk,
  input  logic               rst,
  vote_window_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ZERO = '0;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [N_VOTERS-1:0] votes_r;
  logic [N_VOTERS-1:0] votes_nxt_s;
  logic [N_VOTERS-1:0] merged_s;
  logic [CNT_W-1:0]    timer_r;
  logic [CNT_W-1:0]    timer_nxt_s;
  logic                voting_r;
  logic                done_r;

  // Next-state, next-ballot and next-timer decode.
  always_comb begin
    state_nxt_s = state_r;
    votes_nxt_s = votes_r;
    timer_nxt_s = timer_r;
    // The edge that closes the window still captures the buttons it samples.
    merged_s    = votes_r | bus.btn;

    case (state_r)
      ST_IDLE: begin
        votes_nxt_s = '0;
        timer_nxt_s = TIMER_ZERO;
        if (bus.clear) begin
          state_nxt_s = ST_IDLE;
        end else if (bus.start) begin
          state_nxt_s = ST_VOTING;
          timer_nxt_s = TIMER_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_VOTING: begin
        if (bus.clear) begin
          state_nxt_s = ST_IDLE;
          votes_nxt_s = '0;
          timer_nxt_s = TIMER_ZERO;
        end else if ((timer_r == TIMER_ZERO) || (merged_s == ALL_VOTED)) begin
          state_nxt_s = ST_HOLD;
          votes_nxt_s = merged_s;
          timer_nxt_s = TIMER_ZERO;
        end else begin
          state_nxt_s = ST_VOTING;
          votes_nxt_s = merged_s;
          timer_nxt_s = timer_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      ST_HOLD: begin
        timer_nxt_s = TIMER_ZERO;
        if (bus.clear) begin
          state_nxt_s = ST_IDLE;
          votes_nxt_s = '0;
        end else if (bus.start) begin
          // Back-to-back session: new window opens with an empty ballot.
          state_nxt_s = ST_VOTING;
          votes_nxt_s = '0;
          timer_nxt_s = TIMER_LOAD;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        votes_nxt_s = '0;
        timer_nxt_s = TIMER_ZERO;
      end
    endcase
  end

  // State, ballot, timer and status flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      votes_r  <= '0;
      timer_r  <= TIMER_ZERO;
      voting_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      votes_r  <= votes_nxt_s;
      timer_r  <= timer_nxt_s;
      voting_r <= (state_nxt_s == ST_VOTING);
      done_r   <= (state_nxt_s == ST_HOLD);
    end
  end

  popcount5 u_popcount5 (
    .bits (votes_r),
    .cnt  (bus.vote_cnt)
  );

  assign bus.votes     = votes_r;
  assign bus.voting    = voting_r;
  assign bus.done      = done_r;
  assign bus.remaining = timer_r;

endmodule

// File: tb/tb_vote_window_ctrl.sv
// Self-checking bench for vote_window_ctrl (WINDOW_CYCLES=8, CNT_W=4).
// Directed scenarios followed by random stimulus; every cycle is compared
// against a session-level reference model.
module tb_vote_window_ctrl;
  import vote_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vote_window_ctrl_if #(.CNT_W(CW)) vif ();

  vote_window_ctrl #(.WINDOW_CYCLES(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: is a window open, is a ballot frozen, ballot, cycles left
  bit         m_open;
  bit         m_frozen;
  logic [4:0] m_votes;
  int         m_left;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_open = 1'b0; m_frozen = 1'b0; m_votes = 5'b00000; m_left = 0;
  endtask

  // One clock edge of session rules.
  task automatic model_step(input logic s, input logic c, input logic [4:0] b);
    if (c) begin
      model_reset();
    end else if (m_open) begin
      m_votes = m_votes | b;
      if (m_left == 0 || m_votes == 5'b11111) begin
        m_open = 1'b0; m_frozen = 1'b1; m_left = 0;
      end else begin
        m_left = m_left - 1;
      end
    end else if (s) begin
      m_open = 1'b1; m_frozen = 1'b0; m_votes = 5'b00000; m_left = W - 1;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".voting"},    int'(vif.voting),    int'(m_open));
    check_eq({tag, ".done"},      int'(vif.done),      int'(m_frozen));
    check_eq({tag, ".votes"},     int'(vif.votes),     int'(m_votes));
    check_eq({tag, ".vote_cnt"},  int'(vif.vote_cnt),  $countones(m_votes));
    check_eq({tag, ".remaining"}, int'(vif.remaining), m_left);
  endtask

  // Called at a falling edge: drive inputs, advance model, check after edge.
  task automatic cycle(input logic s, input logic c, input logic [4:0] b);
    vif.start = s; vif.clear = c; vif.btn = b;
    model_step(s, c, b);
    @(posedge clk);
    @(negedge clk);
    vif.start = 1'b0; vif.clear = 1'b0; vif.btn = 5'b00000;
    check_all("cyc");
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int v_cnt;
    int guard;
    int rem_before;
    logic [4:0] b;

    rst = 1'b1;
    vif.start = 1'b0; vif.clear = 1'b0; vif.btn = 5'b00000;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    cycle(1'b0, 1'b0, 5'b00000);

    // Async reset mid-window with a partial ballot
    cycle(1'b1, 1'b0, 5'b00000);
    cycle(1'b0, 1'b0, 5'b00111);
    check_eq("pre_rst.votes", int'(vif.votes), 7);
    async_reset("async_rst");

    // Timeout: votes at window cycles 2 and 5
    v_cnt = 0;
    cycle(1'b1, 1'b0, 5'b00000);
    check_eq("timeout.rem_first", int'(vif.remaining), 7);
    if (vif.voting) v_cnt++;
    for (int i = 0; i < 10; i++) begin
      b = (i == 1) ? 5'b00001 : ((i == 4) ? 5'b00110 : 5'b00000);
      cycle(1'b0, 1'b0, b);
      if (vif.voting) v_cnt++;
    end
    check_eq("timeout.voting_len", v_cnt, 8);
    check_eq("timeout.votes", int'(vif.votes), 7);
    check_eq("timeout.cnt", int'(vif.vote_cnt), 3);
    check_eq("timeout.done", int'(vif.done), 1);

    // Early close on unanimous ballot
    cycle(1'b0, 1'b1, 5'b00000);
    cycle(1'b1, 1'b0, 5'b00000);
    cycle(1'b0, 1'b0, 5'b11111);
    check_eq("early.done", int'(vif.done), 1);
    check_eq("early.cnt", int'(vif.vote_cnt), 5);
    check_eq("early.rem", int'(vif.remaining), 0);

    // Sticky vote and capture on the final window edge
    cycle(1'b0, 1'b1, 5'b00000);
    cycle(1'b1, 1'b0, 5'b00000);
    repeat (2) cycle(1'b0, 1'b0, 5'b10000);
    cycle(1'b0, 1'b0, 5'b00000);
    check_eq("sticky.votes4", int'(vif.votes[4]), 1);
    guard = 0;
    while (vif.remaining != 0 && guard < 20) begin
      cycle(1'b0, 1'b0, 5'b00000);
      guard++;
    end
    check_eq("sticky.wait_bound", int'(guard < 20), 1);
    cycle(1'b0, 1'b0, 5'b01000);
    check_eq("last_edge.done", int'(vif.done), 1);
    check_eq("last_edge.votes", int'(vif.votes), 5'b11000);

    // Priority and abort
    cycle(1'b0, 1'b1, 5'b00000);
    cycle(1'b1, 1'b1, 5'b00000);
    check_eq("start_clear.voting", int'(vif.voting), 0);
    cycle(1'b1, 1'b0, 5'b00000);
    cycle(1'b0, 1'b0, 5'b00011);
    rem_before = int'(vif.remaining);
    cycle(1'b1, 1'b0, 5'b00000);
    check_eq("start_in_voting.rem", int'(vif.remaining), rem_before - 1);
    cycle(1'b0, 1'b1, 5'b00000);
    check_eq("clear_in_voting.votes", int'(vif.votes), 0);
    check_eq("clear_in_voting.voting", int'(vif.voting), 0);

    // Back-to-back session from HOLD
    cycle(1'b1, 1'b0, 5'b00000);
    cycle(1'b0, 1'b0, 5'b10101);
    repeat (8) cycle(1'b0, 1'b0, 5'b00000);
    check_eq("b2b.hold_votes", int'(vif.votes), 5'b10101);
    cycle(1'b1, 1'b0, 5'b00000);
    check_eq("b2b.voting", int'(vif.voting), 1);
    check_eq("b2b.votes", int'(vif.votes), 0);
    check_eq("b2b.rem", int'(vif.remaining), 7);
    check_eq("b2b.done", int'(vif.done), 0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rand_rst");
      end else begin
        for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 9) == 0);
        cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0), b);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
